// File: rtl/raid_ecc_engine.sv
// raid_ecc_engine
//
// Storage back end for a three-disk RAID array with SECDED protection.
// Each 16-bit word is stored as two 13-bit SECDED codewords (low byte on
// disk 0, high byte on disk 1) plus a parity codeword on disk 2 that
// encodes the XOR of the two bytes. Reads correct single-bit errors and
// reconstruct a byte from parity when one data disk is uncorrectable.
// A RAID command rebuilds a replaced disk from the other two.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en, write_data   write command and 16-bit word
//   address             word address for write/read/inject
//   rd_en               read command
//   disk_stat           RAID command (3'b111 = none, bit k = 0 -> disk k replaced)
//   inj_en, inj_disk,   debug error injection: disk[inj_disk][address] ^= inj_mask
//   inj_mask
//   wr_done, rd_done,   one-cycle completion pulses
//   raid_done
//   read_data           corrected read word, held until the next read completes
//   err_corrected       last read needed a bit fix or parity reconstruction
//   err_uncorrectable   last read could not be recovered
//   raid_fail           pulses with raid_done when the RAID command was invalid
//   busy                FSM is not in IDLE
//
// Command handshake: every command input is a single-cycle request that is
// accepted only on an edge where busy is low (FSM in IDLE). While busy is
// high requests are dropped, never queued; completion is signalled by the
// matching done pulse, after which the next command may be issued.
//
// Codeword layout: bit i holds Hamming position i+1. Check bits at
// positions 1,2,4,8 (bits 0,1,3,7), data d0..d7 at positions
// 3,5,6,7,9,10,11,12 (bits 2,4,5,6,8,9,10,11), bit 12 is overall parity.

module raid_ecc_engine #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [15:0]       write_data,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd_en,
    input  logic [2:0]        disk_stat,
    input  logic              inj_en,
    input  logic [1:0]        inj_disk,
    input  logic [12:0]       inj_mask,
    output logic              wr_done,
    output logic              rd_done,
    output logic              raid_done,
    output logic [15:0]       read_data,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic              raid_fail,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WRITE      = 3'd1;
    localparam logic [2:0] S_READ_FETCH = 3'd2;
    localparam logic [2:0] S_READ_DEC   = 3'd3;
    localparam logic [2:0] S_REBUILD    = 3'd4;
    localparam logic [2:0] S_INJECT     = 3'd5;

    // ------------------------------------------------------------------
    // SECDED helpers
    // ------------------------------------------------------------------
    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        c     = '0;
        c[2]  = d[0];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[8]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[11] = d[7];
        c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
        c[12] = ^c[11:0];
        return c;
    endfunction

    // Syndrome is the XOR of the Hamming positions of all set bits 0..11.
    function automatic logic [3:0] syndrome(input logic [12:0] c);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 12; i++) begin
            if (c[i]) s = s ^ 4'(i + 1);
        end
        return s;
    endfunction

    // Returns {corrected, uncorrectable}.
    function automatic logic [1:0] dec_flags(input logic [12:0] c);
        logic [3:0] s;
        logic       p;
        s = syndrome(c);
        p = ^c;
        return {(p && (s <= 4'd12)), ((p && (s > 4'd12)) || (!p && (s != 4'd0)))};
    endfunction

    // Applies the single-bit fix; uncorrectable words pass through raw.
    function automatic logic [12:0] corr_cw(input logic [12:0] c);
        logic [12:0] f;
        logic [3:0]  s;
        f = c;
        s = syndrome(c);
        if (^c) begin
            if (s == 4'd0) begin
                f[12] = ~f[12];
            end else begin
                for (int i = 0; i < 12; i++) begin
                    if (4'(i + 1) == s) f[i] = ~f[i];
                end
            end
        end
        return f;
    endfunction

    function automatic logic [7:0] ext(input logic [12:0] c);
        return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        rb_disk;
    logic              rb_invalid;
    logic [1:0]        inj_disk_q;
    logic [12:0]       inj_mask_q;
    logic [ADDR_W-1:0] cnt;
    logic [12:0]       cw0_q, cw1_q, cw2_q;

    logic [12:0] disk0 [0:DEPTH-1];
    logic [12:0] disk1 [0:DEPTH-1];
    logic [12:0] disk2 [0:DEPTH-1];

    assign busy = (state != S_IDLE);

    // Single shared read port per disk: the rebuild sweep uses the counter,
    // every other operation uses the latched command address.
    logic [ADDR_W-1:0] rd_addr;
    logic [12:0]       rd_cw0, rd_cw1, rd_cw2;

    assign rd_addr = (state == S_REBUILD) ? cnt : addr_q;
    assign rd_cw0  = disk0[rd_addr];
    assign rd_cw1  = disk1[rd_addr];
    assign rd_cw2  = disk2[rd_addr];

    // Rebuild source: corrected data of the live disks at the sweep address.
    logic [7:0]  ld0, ld1, ld2;
    logic [12:0] rb_cw;

    assign ld0 = ext(corr_cw(rd_cw0));
    assign ld1 = ext(corr_cw(rd_cw1));
    assign ld2 = ext(corr_cw(rd_cw2));

    always_comb begin
        case (rb_disk)
            2'd0:    rb_cw = enc(ld1 ^ ld2);
            2'd1:    rb_cw = enc(ld0 ^ ld2);
            default: rb_cw = enc(ld0 ^ ld1);
        endcase
    end

    // ------------------------------------------------------------------
    // Array write port
    // ------------------------------------------------------------------
    logic [2:0]        we;
    logic [ADDR_W-1:0] wa;
    logic [12:0]       wd0, wd1, wd2;

    always_comb begin
        we  = 3'b000;
        wa  = addr_q;
        wd0 = '0;
        wd1 = '0;
        wd2 = '0;
        case (state)
            S_WRITE: begin
                we  = 3'b111;
                wd0 = enc(wdata_q[7:0]);
                wd1 = enc(wdata_q[15:8]);
                wd2 = enc(wdata_q[7:0] ^ wdata_q[15:8]);
            end
            S_REBUILD: begin
                if (!rb_invalid) begin
                    wa  = cnt;
                    wd0 = rb_cw;
                    wd1 = rb_cw;
                    wd2 = rb_cw;
                    case (rb_disk)
                        2'd0:    we = 3'b001;
                        2'd1:    we = 3'b010;
                        default: we = 3'b100;
                    endcase
                end
            end
            S_INJECT: begin
                wd0 = rd_cw0 ^ inj_mask_q;
                wd1 = rd_cw1 ^ inj_mask_q;
                wd2 = rd_cw2 ^ inj_mask_q;
                case (inj_disk_q)
                    2'd0:    we = 3'b001;
                    2'd1:    we = 3'b010;
                    2'd2:    we = 3'b100;
                    default: we = 3'b000;
                endcase
            end
            default: ;
        endcase
    end

    // Arrays are deliberately not reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (we[0]) disk0[wa] <= wd0;
        if (we[1]) disk1[wa] <= wd1;
        if (we[2]) disk2[wa] <= wd2;
    end

    // ------------------------------------------------------------------
    // Read combine
    // ------------------------------------------------------------------
    logic [7:0] dd0, dd1, dd2;
    logic [1:0] f0, f1, f2;
    logic       multi_unc;
    logic [7:0] rd_lo, rd_hi;
    logic       rd_corr, rd_unc;

    assign dd0 = ext(corr_cw(cw0_q));
    assign dd1 = ext(corr_cw(cw1_q));
    assign dd2 = ext(corr_cw(cw2_q));
    assign f0  = dec_flags(cw0_q);
    assign f1  = dec_flags(cw1_q);
    assign f2  = dec_flags(cw2_q);

    assign multi_unc = (f0[0] & f1[0]) | (f0[0] & f2[0]) | (f1[0] & f2[0]);

    always_comb begin
        rd_lo   = dd0;
        rd_hi   = dd1;
        rd_corr = f0[1] | f1[1] | f2[1];
        rd_unc  = 1'b0;
        if (multi_unc) begin
            rd_corr = 1'b0;
            rd_unc  = 1'b1;
        end else if (f0[0]) begin
            rd_lo   = dd1 ^ dd2;
            rd_corr = 1'b1;
        end else if (f1[0]) begin
            rd_hi   = dd0 ^ dd2;
            rd_corr = 1'b1;
        end else if (f2[0]) begin
            // Data disks are fine; only the parity copy is lost.
            rd_corr = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic one_zero;
    assign one_zero = (disk_stat == 3'b110) || (disk_stat == 3'b101) ||
                      (disk_stat == 3'b011);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            rb_disk           <= '0;
            rb_invalid        <= 1'b0;
            inj_disk_q        <= 2'd3;
            inj_mask_q        <= '0;
            cnt               <= '0;
            cw0_q             <= '0;
            cw1_q             <= '0;
            cw2_q             <= '0;
            wr_done           <= 1'b0;
            rd_done           <= 1'b0;
            raid_done         <= 1'b0;
            raid_fail         <= 1'b0;
            read_data         <= '0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
        end else begin
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            raid_done <= 1'b0;
            raid_fail <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_en) begin
                        addr_q  <= address;
                        wdata_q <= write_data;
                        state   <= S_WRITE;
                    end else if (rd_en) begin
                        addr_q <= address;
                        state  <= S_READ_FETCH;
                    end else if (disk_stat != 3'b111) begin
                        rb_invalid <= !one_zero;
                        rb_disk    <= !disk_stat[0] ? 2'd0 :
                                      !disk_stat[1] ? 2'd1 : 2'd2;
                        cnt        <= '0;
                        state      <= S_REBUILD;
                    end else if (inj_en) begin
                        addr_q     <= address;
                        inj_disk_q <= inj_disk;
                        inj_mask_q <= inj_mask;
                        state      <= S_INJECT;
                    end
                end
                S_WRITE: begin
                    wr_done <= 1'b1;
                    state   <= S_IDLE;
                end
                S_READ_FETCH: begin
                    cw0_q <= rd_cw0;
                    cw1_q <= rd_cw1;
                    cw2_q <= rd_cw2;
                    state <= S_READ_DEC;
                end
                S_READ_DEC: begin
                    read_data         <= {rd_hi, rd_lo};
                    err_corrected     <= rd_corr;
                    err_uncorrectable <= rd_unc;
                    rd_done           <= 1'b1;
                    state             <= S_IDLE;
                end
                S_REBUILD: begin
                    if (rb_invalid) begin
                        raid_done <= 1'b1;
                        raid_fail <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == {ADDR_W{1'b1}}) begin
                            raid_done <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_INJECT: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raid_ecc_engine.sv
// tb_raid_ecc_engine
//
// Directed bench for raid_ecc_engine: write/read round trips, single and
// double error injection, parity reconstruction, uncorrectable reads,
// command priority, full-disk rebuild, invalid RAID command and reset
// during a rebuild. Read words are checked through an expected queue.

module tb_raid_ecc_engine;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 1'b0;
    logic [15:0] write_data = '0;
    logic [7:0]  address = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  disk_stat = 3'b111;
    logic        inj_en = 1'b0;
    logic [1:0]  inj_disk = 2'd3;
    logic [12:0] inj_mask = '0;
    logic        wr_done, rd_done, raid_done;
    logic [15:0] read_data;
    logic        err_corrected, err_uncorrectable, raid_fail, busy;

    raid_ecc_engine #(.ADDR_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .write_data        (write_data),
        .address           (address),
        .rd_en             (rd_en),
        .disk_stat         (disk_stat),
        .inj_en            (inj_en),
        .inj_disk          (inj_disk),
        .inj_mask          (inj_mask),
        .wr_done           (wr_done),
        .rd_done           (rd_done),
        .raid_done         (raid_done),
        .read_data         (read_data),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .raid_fail         (raid_fail),
        .busy              (busy)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] fill_word(input logic [7:0] a);
        return {a ^ 8'hC3, ~a};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; address = a; write_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        check("wr_done_s1", wr_done, 1'b1);
        @(posedge clk); #1;
        check("wr_done_s2", wr_done, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] d,
                           input logic corr, input logic unc);
        logic [15:0] e;
        exp_q.push_back(d);
        @(negedge clk);
        rd_en = 1'b1; address = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rd_done_s1"}, rd_done, 1'b0);
        @(posedge clk); #1;
        check({tag, "_rd_done_s2"}, rd_done, 1'b1);
        e = exp_q.pop_front();
        check({tag, "_data"}, read_data, e);
        check({tag, "_corr"}, err_corrected, corr);
        check({tag, "_unc"}, err_uncorrectable, unc);
        @(posedge clk); #1;
        check({tag, "_rd_done_s3"}, rd_done, 1'b0);
    endtask

    task automatic do_inject(input logic [1:0] dsk, input logic [7:0] a, input logic [12:0] m);
        @(negedge clk);
        inj_en = 1'b1; inj_disk = dsk; address = a; inj_mask = m;
        @(posedge clk); #1;
        inj_en = 1'b0; inj_disk = 2'd3;
        @(posedge clk); #1;
        check("inject_back_idle", busy, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  done_at;
        bit  busy_ok;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_done", wr_done, 1'b0);
        check("rst_rd_done", rd_done, 1'b0);
        check("rst_raid_done", raid_done, 1'b0);
        check("rst_raid_fail", raid_fail, 1'b0);
        check("rst_read_data", read_data, 16'h0000);
        check("rst_corr", err_corrected, 1'b0);
        check("rst_unc", err_uncorrectable, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // clean round trip
        do_write(8'h10, 16'hA55A);
        do_read("clean", 8'h10, 16'hA55A, 1'b0, 1'b0);

        // single data-bit error on disk 0
        do_write(8'h20, 16'h1234);
        do_inject(2'd0, 8'h20, 13'h0004);
        do_read("single_d0", 8'h20, 16'h1234, 1'b1, 1'b0);

        // double error on disk 1 -> parity reconstruction
        do_write(8'h30, 16'hBEEF);
        do_inject(2'd1, 8'h30, 13'h0003);
        do_read("recon_d1", 8'h30, 16'hBEEF, 1'b1, 1'b0);

        // double errors on disks 0 and 1 -> unrecoverable, raw data (check bits only hit)
        do_write(8'h40, 16'hCAFE);
        do_inject(2'd0, 8'h40, 13'h0003);
        do_inject(2'd1, 8'h40, 13'h0003);
        do_read("unc_d01", 8'h40, 16'hCAFE, 1'b0, 1'b1);

        // parity disk alone uncorrectable
        do_write(8'h48, 16'h5AA5);
        do_inject(2'd2, 8'h48, 13'h0003);
        do_read("unc_d2", 8'h48, 16'h5AA5, 1'b1, 1'b0);

        // overall-parity bit flip on disk 1
        do_write(8'h60, 16'h0F1E);
        do_inject(2'd1, 8'h60, 13'h1000);
        do_read("par_bit", 8'h60, 16'h0F1E, 1'b1, 1'b0);

        // inj_disk = 3 is a no-op
        do_inject(2'd3, 8'h10, 13'h0003);
        do_read("inj_noop", 8'h10, 16'hA55A, 1'b0, 1'b0);

        // wr_en wins over rd_en
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; address = 8'h50; write_data = 16'h0F0F;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
        check("prio_wr_done", wr_done, 1'b1);
        check("prio_no_read", rd_done, 1'b0);
        @(posedge clk); #1;
        check("prio_no_read_late", rd_done, 1'b0);
        do_read("prio", 8'h50, 16'h0F0F, 1'b0, 1'b0);

        // fill every address
        for (int a = 0; a < 256; a++) begin
            do_write(8'(a), fill_word(8'(a)));
        end

        // corrupt disk 0 at 0x05 then rebuild disk 0
        do_inject(2'd0, 8'h05, 13'h0003);
        @(negedge clk);
        disk_stat = 3'b110;
        @(posedge clk); #1;
        disk_stat = 3'b111;
        done_at = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (raid_done) begin
                done_at = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check("rebuild_done_cycle", done_at, 256);
        check("rebuild_busy", busy_ok, 1'b1);
        check("rebuild_no_fail", raid_fail, 1'b0);
        @(posedge clk); #1;
        check("rebuild_done_drop", raid_done, 1'b0);
        check("rebuild_idle", busy, 1'b0);
        do_read("rebuilt_05", 8'h05, fill_word(8'h05), 1'b0, 1'b0);
        do_read("rebuilt_ff", 8'hFF, fill_word(8'hFF), 1'b0, 1'b0);

        // invalid RAID command
        @(negedge clk);
        disk_stat = 3'b100;
        @(posedge clk); #1;
        disk_stat = 3'b111;
        check("inv_busy", busy, 1'b1);
        @(posedge clk); #1;
        check("inv_raid_done", raid_done, 1'b1);
        check("inv_raid_fail", raid_fail, 1'b1);
        @(posedge clk); #1;
        check("inv_raid_done_drop", raid_done, 1'b0);
        check("inv_raid_fail_drop", raid_fail, 1'b0);
        check("inv_idle", busy, 1'b0);
        do_read("after_inv", 8'h05, fill_word(8'h05), 1'b0, 1'b0);

        // reset during a rebuild of disk 1, at sweep address 100
        @(negedge clk);
        disk_stat = 3'b101;
        @(posedge clk); #1;
        disk_stat = 3'b111;
        repeat (100) @(posedge clk);
        #1;
        check("mid_rebuild_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_raid_done", raid_done, 1'b0);
        check("mid_rst_raid_fail", raid_fail, 1'b0);
        check("mid_rst_wr_done", wr_done, 1'b0);
        check("mid_rst_rd_done", rd_done, 1'b0);
        check("mid_rst_read_data", read_data, 16'h0000);
        check("mid_rst_corr", err_corrected, 1'b0);
        check("mid_rst_unc", err_uncorrectable, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_no_done", raid_done, 1'b0);
        do_read("post_rst_05", 8'h05, fill_word(8'h05), 1'b0, 1'b0);
        do_read("post_rst_80", 8'h80, fill_word(8'h80), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
